coin_feeder: RTL and testbench

- Transmit side of the coin-pulse interface used by the vending FSM: it drives the single-cycle one-coin and half-coin pulses that the vending FSM consumes.
- It replays a programmed purchase pattern of up to 4 coins, monitors the returned cola/change pulses, and reports each transaction's outcome.
- Used as the on-board stimulus/customer model in front of the vending FSM, driven by a key handler or test controller.

---
 rtl/vend_pkg.sv | 25 ++
 rtl/cycle_timer.sv | 26 ++
 rtl/coin_feeder.sv | 140 ++++++++++++++
 tb/tb_coin_feeder.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared coin, result and state encodings for the coin feeder and the vending FSM.
package vend_pkg;

    localparam logic [1:0] COIN_END  = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    localparam logic [1:0] RES_NONE   = 2'b00;
    localparam logic [1:0] RES_COLA   = 2'b01;
    localparam logic [1:0] RES_CHANGE = 2'b11;

    typedef enum logic [4:0] {
        ST_IDLE = 5'b00001,
        ST_SEND = 5'b00010,
        ST_GAP  = 5'b00100,
        ST_WAIT = 5'b01000,
        ST_DONE = 5'b10000
    } feeder_state_t;

    // 11 is treated as an end marker, same as 00.
    function automatic logic is_coin(input logic [1:0] code);
        return (code == COIN_HALF) || (code == COIN_ONE);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; a load always wins over a decrement.
module cycle_timer #(
    parameter int W = 5
) (
    input  logic         i_sysclk,
    input  logic         i_sysrst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n)
            cnt <= '0;
        else if (i_load)
            cnt <= i_load_val;
        else if (i_dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/coin_feeder.sv
// Replays a programmed coin pattern into the vending FSM and reports the outcome.
module coin_feeder
    import vend_pkg::*;
#(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst_n,
    input  logic             i_start,
    input  logic [7:0]       i_pattern,
    input  logic             i_cola,
    input  logic             i_change,
    output logic             o_money_one,
    output logic             o_money_half,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_result,
    output logic             o_timeout,
    output logic [2:0]       o_coins_sent,
    output logic [CNT_W-1:0] o_cola_cnt
);

    localparam int MAXV = (GAP_CYCLES > TIMEOUT) ? GAP_CYCLES : TIMEOUT;
    localparam int TW   = $clog2(MAXV + 1);
    // The timer is loaded with N-1 so that a phase ends on the cycle it reads zero.
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(TIMEOUT - 1);

    feeder_state_t state;
    logic [7:0]    pat_q;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_dec;
    logic          tmr_zero;
    logic          go_send;

    assign go_send = is_coin(pat_q[1:0]) && (o_coins_sent < 3'd4);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        tmr_dec  = (state == ST_GAP) || (state == ST_WAIT);
        if (state == ST_SEND) begin
            tmr_load = 1'b1;
        end else if ((state == ST_GAP) && !i_cola && tmr_zero && !go_send) begin
            tmr_load = 1'b1;
            tmr_val  = WAIT_LOAD;
        end
    end

    cycle_timer #(.W(TW)) u_timer (
        .i_sysclk   (i_sysclk),
        .i_sysrst_n (i_sysrst_n),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_dec      (tmr_dec),
        .o_zero     (tmr_zero)
    );

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state        <= ST_IDLE;
            pat_q        <= '0;
            o_money_one  <= 1'b0;
            o_money_half <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_result     <= RES_NONE;
            o_timeout    <= 1'b0;
            o_coins_sent <= '0;
            o_cola_cnt   <= '0;
        end else begin
            o_money_one  <= 1'b0;
            o_money_half <= 1'b0;
            o_done       <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start && is_coin(i_pattern[1:0])) begin
                        pat_q        <= i_pattern;
                        o_coins_sent <= '0;
                        o_result     <= RES_NONE;
                        o_timeout    <= 1'b0;
                        o_busy       <= 1'b1;
                        o_money_half <= (i_pattern[1:0] == COIN_HALF);
                        o_money_one  <= (i_pattern[1:0] == COIN_ONE);
                        state        <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    o_coins_sent <= o_coins_sent + 3'd1;
                    pat_q        <= {2'b00, pat_q[7:2]};
                    state        <= ST_GAP;
                end
                ST_GAP: begin
                    // A cola here means the price is already met: drop the remaining slots.
                    if (i_cola) begin
                        o_result <= i_change ? RES_CHANGE : RES_COLA;
                        o_done   <= 1'b1;
                        if (o_cola_cnt != '1)
                            o_cola_cnt <= o_cola_cnt + 1'b1;
                        state <= ST_DONE;
                    end else if (tmr_zero) begin
                        if (go_send) begin
                            o_money_half <= (pat_q[1:0] == COIN_HALF);
                            o_money_one  <= (pat_q[1:0] == COIN_ONE);
                            state        <= ST_SEND;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_cola) begin
                        o_result <= i_change ? RES_CHANGE : RES_COLA;
                        o_done   <= 1'b1;
                        if (o_cola_cnt != '1)
                            o_cola_cnt <= o_cola_cnt + 1'b1;
                        state <= ST_DONE;
                    end else if (tmr_zero) begin
                        o_result  <= RES_NONE;
                        o_timeout <= 1'b1;
                        o_done    <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder: pulse timing, responses, timeout, busy-start and reset abort.
module tb_coin_feeder;

    logic       i_sysclk = 1'b0;
    logic       i_sysrst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_pattern = '0;
    logic       i_cola = 1'b0;
    logic       i_change = 1'b0;
    logic       o_money_one, o_money_half, o_busy, o_done, o_timeout;
    logic [1:0] o_result;
    logic [2:0] o_coins_sent;
    logic [1:0] o_cola_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    coin_feeder #(.GAP_CYCLES(2), .TIMEOUT(16), .CNT_W(2)) dut (
        .i_sysclk     (i_sysclk),
        .i_sysrst_n   (i_sysrst_n),
        .i_start      (i_start),
        .i_pattern    (i_pattern),
        .i_cola       (i_cola),
        .i_change     (i_change),
        .o_money_one  (o_money_one),
        .o_money_half (o_money_half),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_timeout    (o_timeout),
        .o_coins_sent (o_coins_sent),
        .o_cola_cnt   (o_cola_cnt)
    );

    always #5 i_sysclk = ~i_sysclk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_sysclk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".one"},  16'(o_money_one),  16'd0);
        chk({tag, ".half"}, 16'(o_money_half), 16'd0);
        chk({tag, ".done"}, 16'(o_done),       16'd0);
        chk({tag, ".busy"}, 16'(o_busy),       16'd0);
    endtask

    // Cycle k of the loop is the k-th cycle after the one holding i_start.
    task automatic run_txn(input string name, input logic [7:0] pat, input int n,
                           input logic [31:0] one_m, input logic [31:0] half_m,
                           input int cola_k, input logic chg, input int stray_k,
                           input int restart_k, input int done_k,
                           input logic [1:0] e_res, input logic [2:0] e_coins,
                           input logic e_to, input logic [1:0] e_cnt);
        i_pattern = pat;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        i_pattern = ~pat;
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("%s.one@%0d", name, k),  16'(o_money_one),  16'(one_m[k]));
            chk($sformatf("%s.half@%0d", name, k), 16'(o_money_half), 16'(half_m[k]));
            chk($sformatf("%s.done@%0d", name, k), 16'(o_done),       16'(k == done_k));
            chk($sformatf("%s.busy@%0d", name, k), 16'(o_busy),       16'(k <= done_k));
            if (k == done_k) begin
                chk({name, ".result"}, 16'(o_result),     16'(e_res));
                chk({name, ".coins"},  16'(o_coins_sent), 16'(e_coins));
                chk({name, ".tmo"},    16'(o_timeout),    16'(e_to));
                chk({name, ".cnt"},    16'(o_cola_cnt),   16'(e_cnt));
            end
            i_cola   = (k == cola_k);
            i_change = (k == cola_k) ? chg : (k == stray_k);
            i_start  = (k == restart_k);
            tick();
        end
        i_cola   = 1'b0;
        i_change = 1'b0;
        i_start  = 1'b0;
        chk({name, ".hold_res"},   16'(o_result),     16'(e_res));
        chk({name, ".hold_coins"}, 16'(o_coins_sent), 16'(e_coins));
    endtask

    initial begin
        #12;
        chk_idle("rst");
        chk("rst.result", 16'(o_result),     16'd0);
        chk("rst.tmo",    16'(o_timeout),    16'd0);
        chk("rst.coins",  16'(o_coins_sent), 16'd0);
        chk("rst.cnt",    16'(o_cola_cnt),   16'd0);
        @(negedge i_sysclk);
        i_sysrst_n = 1'b1;
        tick();

        // Exact price: 1 + 1 + 0.5, stray change without cola at cycle 5.
        run_txn("exact", 8'b00_01_10_10, 11, 32'h12, 32'h80, 8, 1'b0, 5, 0, 9,
                2'b01, 3'd3, 1'b0, 2'd1);

        // Start with an end code in slot0 is ignored.
        i_pattern = 8'b10_10_10_00;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        for (int k = 1; k <= 4; k++) chk_idle($sformatf("ign@%0d", k));

        run_txn("over", 8'b00_10_10_10, 11, 32'h92, 32'h0, 8, 1'b1, 0, 0, 9,
                2'b11, 3'd3, 1'b0, 2'd2);

        // Cola right after the first coin aborts the rest of the pattern.
        run_txn("early", 8'b10_01_10_10, 10, 32'h2, 32'h0, 2, 1'b0, 0, 0, 3,
                2'b01, 3'd1, 1'b0, 2'd3);

        run_txn("tmo", 8'b00_00_10_10, 25, 32'h12, 32'h0, 0, 1'b0, 0, 0, 23,
                2'b00, 3'd2, 1'b1, 2'd3);

        // Second start at cycle 2 is ignored; counter already saturated at 3.
        run_txn("busy", 8'b00_01_10_10, 11, 32'h12, 32'h80, 8, 1'b0, 0, 2, 9,
                2'b01, 3'd3, 1'b0, 2'd3);

        // Reset asserted mid-transaction, checked before the next clock edge.
        i_pattern = 8'b00_01_10_10;
        i_start   = 1'b1;
        tick();
        i_start   = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("rstx.busy_pre", 16'(o_busy), 16'd1);
        #1;
        i_sysrst_n = 1'b0;
        #1;
        chk_idle("rstx");
        chk("rstx.coins",  16'(o_coins_sent), 16'd0);
        chk("rstx.result", 16'(o_result),     16'd0);
        chk("rstx.cnt",    16'(o_cola_cnt),   16'd0);
        tick();
        tick();
        i_sysrst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_idle($sformatf("post@%0d", k));
        end

        run_txn("clean", 8'b00_00_00_10, 6, 32'h2, 32'h0, 2, 1'b0, 0, 0, 3,
                2'b01, 3'd1, 1'b0, 2'd1);

        // Four half coins use every slot, then the response arrives in the wait phase.
        run_txn("four", 8'b01_01_01_01, 17, 32'h0, 32'h492, 14, 1'b0, 0, 0, 15,
                2'b01, 3'd4, 1'b0, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
